// File: rtl/clken_gen.sv
// Fractional clock-enable generator: NUM_CH strobes at refclk*num/den, with a PLL-style lock indication.
// Latency: ce is registered; the first step follows the lock or sync edge by one cycle.
// Backpressure: cfg_ready follows locked; a write offered while unlocked is dropped.
module clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 8,
    parameter int DEF_NUM     = 1,
    parameter int DEF_DEN     = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_num,
    input  logic [DIV_W-1:0]  cfg_den,
    output logic              cfg_err,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int                LC_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [CH_W:0]     NUM_CH_V  = (CH_W + 1)'(NUM_CH);
    localparam logic [LC_W-1:0]   LOCK_INIT = LC_W'(LOCK_CYCLES);
    localparam logic [DIV_W-1:0]  DEF_NUM_V = DIV_W'(DEF_NUM);
    localparam logic [DIV_W-1:0]  DEF_DEN_V = DIV_W'(DEF_DEN);

    logic [DIV_W-1:0]  num_q    [NUM_CH];
    logic [DIV_W-1:0]  den_q    [NUM_CH];
    logic [DIV_W-1:0]  acc_q    [NUM_CH];
    logic [DIV_W-1:0]  acc_step [NUM_CH];
    logic [NUM_CH-1:0] ce_step;
    logic [LC_W-1:0]   lock_cnt;
    logic              cfg_fire;
    logic              cfg_bad;

    assign cfg_ready = locked;
    assign cfg_fire  = cfg_valid & locked;
    assign cfg_bad   = ({1'b0, cfg_ch} >= NUM_CH_V) || (cfg_den == '0) || (cfg_num > cfg_den);

    // One extra bit on the sum so acc+num never wraps before the compare.
    always_comb begin
        logic [DIV_W:0] sum;
        logic [DIV_W:0] diff;
        sum     = '0;
        diff    = '0;
        ce_step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_step[i] = '0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            sum         = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
            diff        = sum - {1'b0, den_q[i]};
            ce_step[i]  = (sum >= {1'b0, den_q[i]});
            acc_step[i] = ce_step[i] ? diff[DIV_W-1:0] : sum[DIV_W-1:0];
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_q[i] <= DEF_NUM_V;
                den_q[i] <= DEF_DEN_V;
                acc_q[i] <= '0;
            end
            ce       <= '0;
            cfg_err  <= 1'b0;
            locked   <= 1'b0;
            lock_cnt <= LOCK_INIT;
        end else begin
            // A rejected write only raises cfg_err; the channels keep stepping.
            cfg_err <= cfg_fire & cfg_bad;
            if (cfg_fire && !cfg_bad) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cfg_ch == CH_W'(i)) begin
                        num_q[i] <= cfg_num;
                        den_q[i] <= cfg_den;
                    end
                    acc_q[i] <= '0;
                end
                ce       <= '0;
                locked   <= 1'b0;
                lock_cnt <= LOCK_INIT;
            end else if (!locked) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= '0;
                end
                ce <= '0;
                if (lock_cnt != '0) begin
                    lock_cnt <= lock_cnt - LC_W'(1);
                    if (lock_cnt == LC_W'(1)) begin
                        locked <= 1'b1;
                    end
                end
            end else if (sync) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= '0;
                end
                ce <= '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_q[i] <= acc_step[i];
                end
                ce <= ce_step;
            end
        end
    end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: per-edge expectations queued by the stimulus, checked by a negedge monitor.
module tb_clken_gen;

    logic        refclk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic        cfg_err;
    logic        sync;
    logic [3:0]  ce;
    logic        locked;

    clken_gen #(
        .NUM_CH(4), .DIV_W(16), .LOCK_CYCLES(8), .DEF_NUM(1), .DEF_DEN(1)
    ) dut (
        .refclk(refclk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .sync(sync), .ce(ce), .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic [3:0] ce;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: ratios written by the stimulus, lock countdown, and steps since the phase origin.
    int   m_num[4];
    int   m_den[4];
    logic m_locked;
    int   m_lock_left;
    int   m_t;
    logic rst_req;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_num[i] = 1;
            m_den[i] = 1;
        end
        m_locked    = 1'b0;
        m_lock_left = 8;
        m_t         = 0;
    endtask

    // With the accumulator starting at 0, step t fires exactly when floor(t*num/den) increments.
    function automatic logic fires(int t, int n, int d);
        if (n == 0) return 1'b0;
        return ((t * n) / d) != (((t - 1) * n) / d);
    endfunction

    task automatic cycle(input logic v, input logic [1:0] ch, input logic [15:0] n,
                         input logic [15:0] d, input logic s);
        exp_t e;
        logic acc;
        logic bad;
        logic rst_prev;
        @(negedge refclk);
        #1;
        rst_prev  = rst;
        rst       = rst_req;
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_num   = n;
        cfg_den   = d;
        sync      = s;
        if (rst_req && !rst_prev) begin
            #1;
            checks++;
            if (ce !== 4'b0 || locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
                errors++;
                $display("FAIL async_reset: ce=%b locked=%b ready=%b err=%b, want all zero",
                         ce, locked, cfg_ready, cfg_err);
            end
        end
        @(posedge refclk);
        e = '0;
        if (rst_req) begin
            model_reset();
        end else begin
            acc   = v && m_locked;
            bad   = (d == 16'd0) || (n > d);
            e.err = acc && bad;
            if (acc && !bad) begin
                m_num[ch]   = int'(n);
                m_den[ch]   = int'(d);
                m_locked    = 1'b0;
                m_lock_left = 8;
                m_t         = 0;
            end else if (!m_locked) begin
                if (m_lock_left != 0) begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        m_locked = 1'b1;
                        m_t      = 0;
                    end
                end
            end else if (s) begin
                m_t = 0;
            end else begin
                m_t++;
                for (int i = 0; i < 4; i++) begin
                    e.ce[i] = fires(m_t, m_num[i], m_den[i]);
                end
            end
        end
        e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 2'd0, 16'd0, 16'd0, 1'b0);
    endtask

    // Monitor: every edge with a queued expectation is compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge refclk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({locked, cfg_ready, cfg_err, ce} !== {e.locked, e.locked, e.err, e.ce}) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: locked=%b ready=%b err=%b ce=%b, want locked=%b ready=%b err=%b ce=%b",
                             cyc, locked, cfg_ready, cfg_err, ce, e.locked, e.locked, e.err, e.ce);
                end
            end
        end
    end

    initial begin
        int pulses;
        int last;
        int bad_gap;
        rst       = 1'b1;
        rst_req   = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_num   = '0;
        cfg_den   = '0;
        sync      = 1'b0;
        model_reset();
        repeat (2) @(negedge refclk);
        #1;
        checks++;
        if (ce !== 4'b0 || locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ce=%b locked=%b ready=%b err=%b, want all zero",
                     ce, locked, cfg_ready, cfg_err);
        end
        rst_req = 1'b0;

        // Defaults 1/1: lock on the 8th edge, then all channels every cycle.
        idle(14);

        // ch1 = 1/4; a write offered while relocking must be dropped.
        cycle(1'b1, 2'd1, 16'd1, 16'd4, 1'b0);
        idle(3);
        cycle(1'b1, 2'd0, 16'd1, 16'd2, 1'b0);
        idle(20);

        // ch2 = 3/8, then count pulses over 800 locked cycles.
        cycle(1'b1, 2'd2, 16'd3, 16'd8, 1'b0);
        idle(8);
        pulses  = 0;
        last    = -1;
        bad_gap = 0;
        for (int t = 1; t <= 800; t++) begin
            idle(1);
            #1;
            if (ce[2] === 1'b1) begin
                if (last >= 0 && (t - last < 2 || t - last > 3)) bad_gap++;
                last = t;
                pulses++;
            end
        end
        checks++;
        if (pulses != 300) begin
            errors++;
            $display("FAIL ch2_pulse_count: got %0d, want 300", pulses);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL ch2_spacing: %0d gaps outside 2..3 cycles, want 0", bad_gap);
        end

        // Rejected writes: den=0, then num>den; lock and ce streams continue.
        cycle(1'b1, 2'd0, 16'd1, 16'd0, 1'b0);
        idle(2);
        cycle(1'b1, 2'd3, 16'd5, 16'd4, 1'b0);
        idle(5);

        // ch0 = 1/3, ch1 = 1/5, then sync; then sync together with a write.
        cycle(1'b1, 2'd0, 16'd1, 16'd3, 1'b0);
        idle(8);
        cycle(1'b1, 2'd1, 16'd1, 16'd5, 1'b0);
        idle(12);
        cycle(1'b0, 2'd0, 16'd0, 16'd0, 1'b1);
        idle(12);
        cycle(1'b1, 2'd3, 16'd2, 16'd3, 1'b1);
        idle(14);

        // Mid-stream reset: outputs clear at once, defaults return, relock after 8 edges.
        rst_req = 1'b1;
        idle(2);
        rst_req = 1'b0;
        idle(14);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge refclk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
